daq_frame_packer: RTL and testbench

Multi-channel ADC sample framer feeding the FT232H byte-send path. It sits in the ft_clk domain after the ADC async FIFO read side. Each accepted multi-channel sample becomes a framed byte stream: sync word, sequence number, flags, then little-endian 16-bit samples. It adds a built-in ramp test-pattern mode and overflow/drop accounting, neither of which the current single-channel raw path has.

---
 rtl/daq_pkg.sv | 18 +
 rtl/daq_frame_packer_if.sv | 27 ++
 rtl/daq_sat_counter.sv | 27 ++
 rtl/daq_frame_packer.sv | 141 ++++++++++++++
 tb/tb_daq_frame_packer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/daq_pkg.sv
// Shared constants, state type and frame-length helper for the ADC frame packer.
package daq_pkg;

  localparam logic [7:0] SYNC0   = 8'hA5;
  localparam logic [7:0] SYNC1   = 8'h5A;
  localparam int         HDR_LEN = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } pack_state_t;

  function automatic int frame_len(input int num_ch);
    return HDR_LEN + 2 * num_ch;
  endfunction

endpackage

// File: rtl/daq_frame_packer_if.sv
// Sample-in / byte-out handshake bundle of the frame packer, plus drop accounting.
interface daq_frame_packer_if #(
  parameter int NUM_CH     = 4,
  parameter int SAMPLE_W   = 12,
  parameter int DROP_CNT_W = 16
);
  logic                       s_valid_i;
  logic [NUM_CH*SAMPLE_W-1:0] s_data_i;
  logic                       s_ready_o;
  logic                       test_en_i;
  logic                       m_valid_o;
  logic [7:0]                 m_data_o;
  logic                       m_last_o;
  logic                       m_ready_i;
  logic [DROP_CNT_W-1:0]      drop_cnt_o;
  logic                       drop_clr_i;

  modport slave (
    input  s_valid_i, s_data_i, test_en_i, m_ready_i, drop_clr_i,
    output s_ready_o, m_valid_o, m_data_o, m_last_o, drop_cnt_o
  );

  modport master (
    output s_valid_i, s_data_i, test_en_i, m_ready_i, drop_clr_i,
    input  s_ready_o, m_valid_o, m_data_o, m_last_o, drop_cnt_o
  );
endinterface

// File: rtl/daq_sat_counter.sv
// Saturating up-counter; a clear coinciding with an increment lands on one.
module daq_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_r;

  // Counter register with clear priority and saturation at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= '0;
    end else if (clr_i) begin
      cnt_r <= inc_i ? W'(1'b1) : '0;
    end else if (inc_i && (cnt_r != '1)) begin
      cnt_r <= cnt_r + W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt_o = cnt_r;
endmodule

// File: rtl/daq_frame_packer.sv
// Frames each accepted multi-channel sample set as a sync/seq/flags header plus
// little-endian 16-bit samples, with ramp test pattern and drop accounting.
module daq_frame_packer
  import daq_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int SAMPLE_W   = 12,
  parameter int DROP_CNT_W = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  daq_frame_packer_if.slave bus
);
  localparam int         FRAME_LEN = frame_len(NUM_CH);
  localparam int         SET_W     = 16 * NUM_CH;
  localparam logic [7:0] LAST_IDX  = 8'(FRAME_LEN - 1);
  localparam logic [5:0] CH_CODE   = 6'(NUM_CH - 1);

  pack_state_t         state_r;
  logic [7:0]          idx_r;
  logic [7:0]          seq_r;
  logic [SAMPLE_W-1:0] ramp_r;
  logic                ovf_r;
  logic                test_r;
  logic [SET_W-1:0]    samples_r;
  logic                s_ready_r;
  logic                m_valid_r;
  logic [7:0]          m_data_r;
  logic                m_last_r;

  logic                drop_s;
  logic                accept_s;
  logic                hs_s;
  logic [7:0]          nxt_idx_s;
  logic [7:0]          ofs_s;
  logic [7:0]          payload_byte_s;
  logic [7:0]          nxt_byte_s;
  logic [SET_W-1:0]    load_set_s;

  assign drop_s    = bus.s_valid_i & ~s_ready_r;
  assign accept_s  = bus.s_valid_i & s_ready_r;
  assign hs_s      = m_valid_r & bus.m_ready_i;
  assign nxt_idx_s = idx_r + 8'd1;
  assign ofs_s     = nxt_idx_s - 8'(HDR_LEN);

  // Byte that follows the one currently presented; payload is the sample set in byte order.
  always_comb begin
    payload_byte_s = 8'h00;
    for (int k = 0; k < 2 * NUM_CH; k++) begin
      payload_byte_s = payload_byte_s | ((ofs_s == 8'(k)) ? samples_r[8*k +: 8] : 8'h00);
    end
    nxt_byte_s = 8'h00;
    case (nxt_idx_s)
      8'd1:    nxt_byte_s = SYNC1;
      8'd2:    nxt_byte_s = seq_r;
      // A drop in the very cycle B3 is loaded is still reported in it.
      8'd3:    nxt_byte_s = {ovf_r | drop_s, test_r, CH_CODE};
      default: nxt_byte_s = payload_byte_s;
    endcase
  end

  // Sample set captured on accept: live channels or the ramp, zero-extended to 16 bits.
  always_comb begin
    load_set_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      load_set_s[16*k +: 16] = bus.test_en_i ? 16'(SAMPLE_W'(ramp_r + SAMPLE_W'(k)))
                                             : 16'(bus.s_data_i[k*SAMPLE_W +: SAMPLE_W]);
    end
  end

  // Framing FSM with registered handshake outputs and the pending-overflow flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      idx_r     <= 8'd0;
      seq_r     <= 8'd0;
      ramp_r    <= '0;
      ovf_r     <= 1'b0;
      test_r    <= 1'b0;
      samples_r <= '0;
      s_ready_r <= 1'b1;
      m_valid_r <= 1'b0;
      m_data_r  <= 8'h00;
      m_last_r  <= 1'b0;
    end else begin
      ovf_r <= drop_s ? 1'b1 : ((hs_s && (idx_r == 8'd3)) ? 1'b0 : ovf_r);
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            samples_r <= load_set_s;
            test_r    <= bus.test_en_i;
            ramp_r    <= bus.test_en_i ? ramp_r + SAMPLE_W'(1'b1) : ramp_r;
            s_ready_r <= 1'b0;
            m_valid_r <= 1'b1;
            m_data_r  <= SYNC0;
            m_last_r  <= 1'b0;
            idx_r     <= 8'd0;
            state_r   <= HDR;
          end
        end
        HDR, PAYLOAD: begin
          if (hs_s) begin
            if (m_last_r) begin
              state_r   <= IDLE;
              idx_r     <= 8'd0;
              seq_r     <= seq_r + 8'd1;
              s_ready_r <= 1'b1;
              m_valid_r <= 1'b0;
              m_data_r  <= 8'h00;
              m_last_r  <= 1'b0;
            end else begin
              idx_r    <= nxt_idx_s;
              m_data_r <= nxt_byte_s;
              m_last_r <= (nxt_idx_s == LAST_IDX);
              state_r  <= (nxt_idx_s >= 8'(HDR_LEN)) ? PAYLOAD : HDR;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          s_ready_r <= 1'b1;
          m_valid_r <= 1'b0;
          m_last_r  <= 1'b0;
        end
      endcase
    end
  end

  daq_sat_counter #(.W(DROP_CNT_W)) u_drop_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (bus.drop_clr_i),
    .inc_i (drop_s),
    .cnt_o (bus.drop_cnt_o)
  );

  assign bus.s_ready_o = s_ready_r;
  assign bus.m_valid_o = m_valid_r;
  assign bus.m_data_o  = m_data_r;
  assign bus.m_last_o  = m_last_r;
endmodule

// File: tb/tb_daq_frame_packer.sv
// Randomised and directed bench for daq_frame_packer against a frame-level reference model.
module tb_daq_frame_packer;
  localparam int NUM_CH = 4;
  localparam int SAMPLE_W = 12;
  localparam int DW = 16;
  localparam int FL = 4 + 2 * NUM_CH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  daq_frame_packer_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .DROP_CNT_W(DW)) bus ();

  daq_frame_packer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .DROP_CNT_W(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  bit       m_busy;
  int       m_pos;
  int       m_seq;
  int       m_ramp;
  int       m_cnt;
  bit       m_ovf;
  bit       m_b3ovf;
  bit       m_test;
  int       m_frame[FL];
  logic [7:0] log_q[$];

  logic [7:0] golden[FL] = '{8'hA5, 8'h5A, 8'h00, 8'h03, 8'h23, 8'h01,
                             8'h56, 8'h04, 8'h89, 8'h07, 8'hBC, 8'h0A};
  logic [47:0] d0 = {12'hABC, 12'h789, 12'h456, 12'h123};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_pos = 0; m_seq = 0; m_ramp = 0; m_cnt = 0;
    m_ovf = 1'b0; m_b3ovf = 1'b0; m_test = 1'b0;
  endtask

  task automatic drive_idle();
    bus.s_valid_i = 1'b0; bus.s_data_i = '0; bus.test_en_i = 1'b0;
    bus.m_ready_i = 1'b0; bus.drop_clr_i = 1'b0;
  endtask

  // One clock: check outputs at the falling edge, drive inputs, advance the model.
  task automatic step(input bit sv, input logic [47:0] d, input bit te, input bit mr, input bit clr);
    bit drop, acc, hs;
    int exp_byte;
    int samp[NUM_CH];
    @(negedge clk);
    check("s_ready", 32'(bus.s_ready_o), 32'(!m_busy));
    check("m_valid", 32'(bus.m_valid_o), 32'(m_busy));
    check("drop_cnt", 32'(bus.drop_cnt_o), 32'(m_cnt));
    if (m_busy) begin
      exp_byte = (m_pos == 3) ? ((int'(m_b3ovf) << 7) | (int'(m_test) << 6) | (NUM_CH - 1))
                              : m_frame[m_pos];
      check("m_data", 32'(bus.m_data_o), 32'(exp_byte));
      check("m_last", 32'(bus.m_last_o), 32'(m_pos == FL - 1));
    end else begin
      check("idle_data", 32'(bus.m_data_o), 32'd0);
      check("idle_last", 32'(bus.m_last_o), 32'd0);
    end
    if (bus.m_valid_o && mr) log_q.push_back(bus.m_data_o);
    bus.s_valid_i = sv; bus.s_data_i = d; bus.test_en_i = te;
    bus.m_ready_i = mr; bus.drop_clr_i = clr;
    drop = sv && m_busy;
    acc  = sv && !m_busy;
    hs   = m_busy && mr;
    if (hs && m_pos == 2) m_b3ovf = m_ovf || drop;
    if (drop) m_ovf = 1'b1;
    else if (hs && m_pos == 3) m_ovf = 1'b0;
    if (clr) m_cnt = drop ? 1 : 0;
    else if (drop && m_cnt < (1 << DW) - 1) m_cnt++;
    if (hs) begin
      if (m_pos == FL - 1) begin
        m_busy = 1'b0;
        m_seq = (m_seq + 1) % 256;
      end else begin
        m_pos++;
      end
    end
    if (acc) begin
      for (int k = 0; k < NUM_CH; k++)
        samp[k] = te ? (m_ramp + k) % (1 << SAMPLE_W) : int'((d >> (SAMPLE_W * k)) & 48'hFFF);
      if (te) m_ramp = (m_ramp + 1) % (1 << SAMPLE_W);
      m_frame[0] = 8'hA5; m_frame[1] = 8'h5A; m_frame[2] = m_seq; m_frame[3] = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        m_frame[4 + 2 * k] = samp[k] & 255;
        m_frame[5 + 2 * k] = samp[k] >> 8;
      end
      m_test = te; m_busy = 1'b1; m_pos = 0;
    end
  endtask

  task automatic frame(input logic [47:0] d, input bit te);
    step(1'b1, d, te, 1'b1, 1'b0);
    repeat (FL) step(1'b0, 48'd0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int guard;
    drive_idle();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reference frame with the sink always ready
    log_q.delete();
    frame(d0, 1'b0);
    check("gold_len", 32'(log_q.size()), 32'(FL));
    for (int i = 0; i < FL; i++) check("gold_byte", 32'(log_q[i]), 32'(golden[i]));

    // same frame with the sink stalling every other cycle
    step(1'b1, d0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 26; i++) step(1'b0, 48'd0, 1'b0, bit'(i % 2 == 0), 1'b0);

    // three drops after B3, ovf reported in the next header only
    log_q.delete();
    step(1'b1, d0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < FL; i++) step(bit'(i >= 5 && i <= 7), d0, 1'b0, 1'b1, 1'b0);
    check("drops3", 32'(bus.drop_cnt_o), 32'd3);
    frame(d0, 1'b0);
    frame(d0, 1'b0);
    check("b3_ovf", 32'(log_q[FL + 3]), 32'h83);
    check("b3_clr", 32'(log_q[2 * FL + 3]), 32'h03);

    // ramp pattern
    log_q.delete();
    for (int f = 0; f < 3; f++) frame(48'hFFFF_FFFF_FFFF, 1'b1);
    for (int f = 0; f < 3; f++) begin
      check("ramp_b3", 32'(log_q[FL * f + 3]), 32'h43);
      check("ramp_ch0", 32'(log_q[FL * f + 4]), 32'(f));
      check("ramp_ch3", 32'(log_q[FL * f + 10]), 32'(3 + f));
    end

    // random traffic
    for (int i = 0; i < 3000; i++)
      step(bit'($urandom_range(0, 9) < 3), 48'({$urandom(), $urandom()}), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 9) < 7), bit'($urandom_range(0, 49) == 0));
    repeat (FL + 2) step(1'b0, 48'd0, 1'b0, 1'b1, 1'b0);

    // sequence wrap across 260 frames
    for (int f = 0; f < 260; f++) frame(48'({$urandom(), $urandom()}), 1'b0);

    // drop counter saturation and clear-with-drop
    step(1'b0, 48'd0, 1'b0, 1'b1, 1'b1);
    step(1'b1, d0, 1'b0, 1'b0, 1'b0);
    repeat (65540) step(1'b1, d0, 1'b0, 1'b0, 1'b0);
    check("sat", 32'(bus.drop_cnt_o), 32'hFFFF);
    step(1'b1, d0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 48'd0, 1'b0, 1'b0, 1'b0);
    check("clr_drop", 32'(bus.drop_cnt_o), 32'd1);
    repeat (FL + 2) step(1'b0, 48'd0, 1'b0, 1'b1, 1'b0);

    // reset while payload byte 6 is on the bus
    step(1'b1, d0, 1'b0, 1'b1, 1'b0);
    guard = 0;
    while (!(m_busy && m_pos == 6) && guard < 20) begin
      step(1'b0, 48'd0, 1'b0, 1'b1, 1'b0);
      guard++;
    end
    check("reach_b6", 32'(guard < 20), 32'd1);
    @(posedge clk);
    #2;
    check("pre_rst_valid", 32'(bus.m_valid_o), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mvalid", 32'(bus.m_valid_o), 32'd0);
    check("rst_sready", 32'(bus.s_ready_o), 32'd1);
    drive_idle();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    log_q.delete();
    frame(d0, 1'b0);
    check("post_rst_b0", 32'(log_q[0]), 32'hA5);
    check("post_rst_b1", 32'(log_q[1]), 32'h5A);
    check("post_rst_b2", 32'(log_q[2]), 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
